regfile_mp_sb: RTL and testbench

Parametrised multi-port integer register file with a built-in pending-write scoreboard, the next generation of the LemonPC GPR array. It provides NUM_RD combinational read ports and NUM_WR synchronous write ports, keeps x0 hardwired to zero, tracks which registers await writeback, and optionally bypasses same-cycle write data to readers. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which retires results.

---
 rtl/regfile_mp_sb_pkg.sv | 17 +
 rtl/regfile_mp_sb_rf_wr_select.sv | 32 +++
 rtl/regfile_mp_sb.sv | 112 +++++++++++
 tb/tb_regfile_mp_sb.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults, x0 index and port-slice helper for the regfile_mp_sb register file.
`ifndef RF_SL
`define RF_SL(k, w) ((k)*(w)) +: (w)
`endif

package regfile_mp_sb_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 64;
    localparam int RF_X0         = 0;

    // Width of a write-port index; never zero so NUM_WR=1 still has a legal vector.
    function automatic int rf_win_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_rf_wr_select.sv
// rf_wr_select: resolves which write port (highest index wins) targets one register index,
// and flags when more than one enabled port does. Index x0 never hits.
module rf_wr_select
    import regfile_mp_sb_pkg::*;
#(
    parameter int NUM_WR     = 1,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int WIN_W      = 1
) (
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [ADDR_WIDTH-1:0]        i_idx,
    output logic                         o_hit,
    output logic [WIN_W-1:0]             o_win,
    output logic                         o_multi
);

    always_comb begin
        o_hit   = 1'b0;
        o_win   = '0;
        o_multi = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (i_wr_en[k] && (i_idx != ADDR_WIDTH'(RF_X0)) &&
                (i_wr_addr[`RF_SL(k, ADDR_WIDTH)] == i_idx)) begin
                o_multi = o_multi | o_hit;
                o_hit   = 1'b1;
                o_win   = WIN_W'(k);
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with pending-write scoreboard; x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy clears to the read ports.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic                         iss_en,
    input  logic [ADDR_WIDTH-1:0]        iss_addr,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy_vec,
    output logic                         wr_conflict
);

    localparam int NREG  = 1 << ADDR_WIDTH;
    localparam int WIN_W = rf_win_w(NUM_WR);

    logic [DATA_WIDTH-1:0] w_rf [NREG];
    logic [NREG-1:0]       w_multi;
    logic                  r_conflict;

    assign w_rf[RF_X0]     = '0;
    assign busy_vec[RF_X0] = 1'b0;
    assign w_multi[RF_X0]  = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic                  w_hit;
        logic [WIN_W-1:0]      w_win;
        logic [DATA_WIDTH-1:0] r_q;
        logic                  r_busy;

        rf_wr_select #(
            .NUM_WR     (NUM_WR),
            .ADDR_WIDTH (ADDR_WIDTH),
            .WIN_W      (WIN_W)
        ) u_sel (
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_idx     (ADDR_WIDTH'(i)),
            .o_hit     (w_hit),
            .o_win     (w_win),
            .o_multi   (w_multi[i])
        );

        // A same-cycle issue beats the writeback clear: a newer producer is outstanding.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q    <= '0;
                r_busy <= 1'b0;
            end else begin
                if (w_hit)
                    r_q <= wr_data[`RF_SL(w_win, DATA_WIDTH)];
                if (iss_en && (iss_addr == ADDR_WIDTH'(i)))
                    r_busy <= 1'b1;
                else if (w_hit)
                    r_busy <= 1'b0;
            end
        end

        assign w_rf[i]     = r_q;
        assign busy_vec[i] = r_busy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_conflict <= 1'b0;
        else if (|w_multi)
            r_conflict <= 1'b1;
    end

    assign wr_conflict = r_conflict;

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        assign w_addr = rd_addr[`RF_SL(j, ADDR_WIDTH)];
`ifdef REGFILE_BYPASS_EN
        logic             w_hit;
        logic [WIN_W-1:0] w_win;

        rf_wr_select #(
            .NUM_WR     (NUM_WR),
            .ADDR_WIDTH (ADDR_WIDTH),
            .WIN_W      (WIN_W)
        ) u_byp (
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_idx     (w_addr),
            .o_hit     (w_hit),
            .o_win     (w_win),
            .o_multi   ()
        );

        assign rd_data[`RF_SL(j, DATA_WIDTH)] = w_hit ? wr_data[`RF_SL(w_win, DATA_WIDTH)]
                                                      : w_rf[w_addr];
        assign rd_busy[j] = w_hit ? (iss_en && (iss_addr == w_addr)) : busy_vec[w_addr];
`else
        assign rd_data[`RF_SL(j, DATA_WIDTH)] = w_rf[w_addr];
        assign rd_busy[j] = busy_vec[w_addr];
`endif
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (3 read ports, 2 write ports) against an array model.
module tb_regfile_mp_sb;

    localparam int AW   = 5;
    localparam int DW   = 64;
    localparam int NR   = 3;
    localparam int NW   = 2;
    localparam int NREG = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR*DW-1:0]   rd_data;
    logic [NR-1:0]      rd_busy;
    logic [NW-1:0]      wr_en;
    logic [NW*AW-1:0]   wr_addr;
    logic [NW*DW-1:0]   wr_data;
    logic               iss_en;
    logic [AW-1:0]      iss_addr;
    logic [NREG-1:0]    busy_vec;
    logic               wr_conflict;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_rf [NREG];
    bit            m_busy [NREG];
    bit            m_conf;

    regfile_mp_sb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_RD     (NR),
        .NUM_WR     (NW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .busy_vec    (busy_vec),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_rf[r]   = '0;
            m_busy[r] = 1'b0;
        end
        m_conf = 1'b0;
    endfunction

    function automatic void model_update();
        int cnt [NREG];
        if (rst) begin
            model_reset();
            return;
        end
        for (int r = 0; r < NREG; r++) cnt[r] = 0;
        for (int k = 0; k < NW; k++) begin
            int a;
            a = int'(wr_addr[k*AW +: AW]);
            if (wr_en[k] && a != 0) begin
                m_rf[a]   = wr_data[k*DW +: DW];
                m_busy[a] = 1'b0;
                cnt[a]++;
            end
        end
        for (int r = 1; r < NREG; r++)
            if (cnt[r] > 1) m_conf = 1'b1;
        if (iss_en && iss_addr != 0) m_busy[int'(iss_addr)] = 1'b1;
    endfunction

    function automatic logic [DW-1:0] exp_data(input int a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_rf[a];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NW; k++)
            if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) v = wr_data[k*DW +: DW];
`endif
        return v;
    endfunction

    function automatic bit exp_busy(input int a);
        bit b;
        if (a == 0) return 1'b0;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NW; k++)
            if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a)
                b = iss_en && (int'(iss_addr) == a);
`endif
        return b;
    endfunction

    function automatic logic [NREG-1:0] exp_bvec();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    task automatic set_rd(input int j, input int a);
        rd_addr[j*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int k, input int a, input logic [DW-1:0] d);
        wr_en[k]            = 1'b1;
        wr_addr[k*AW +: AW] = AW'(a);
        wr_data[k*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst     = 1'b1;
        rd_addr = '0;
        idle();
        model_reset();
        #3;
        for (int j = 0; j < NR; j++) set_rd(j, j + 1);
        #1;
        n_vec++;
        if (busy_vec !== '0) begin
            n_err++; $display("FAIL reset_busy_vec got %h want 0", busy_vec);
        end
        n_vec++;
        if (wr_conflict !== 1'b0) begin
            n_err++; $display("FAIL reset_conflict got %b want 0", wr_conflict);
        end
        n_vec++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            n_err++; $display("FAIL reset_rd got data %h busy %b want 0/0", rd_data, rd_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] v, want;
        v = 64'h1234_5678_9ABC_DEF0;
        idle();
        set_rd(0, 3);
        set_wr(0, 3, v);
`ifdef REGFILE_BYPASS_EN
        want = v;
`else
        want = '0;
`endif
        @(negedge clk);
        n_vec++;
        if (rd_data[0 +: DW] !== want) begin
            n_err++; $display("FAIL wr_same_cycle got %h want %h", rd_data[0 +: DW], want);
        end
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if (rd_data[0 +: DW] !== v) begin
            n_err++; $display("FAIL wr_next_cycle got %h want %h", rd_data[0 +: DW], v);
        end
        tick();
    endtask

    task automatic test_x0();
        idle();
        for (int j = 0; j < NR; j++) set_rd(j, 0);
        set_wr(0, 0, 64'hFFFF);
        iss_en   = 1'b1;
        iss_addr = '0;
        @(negedge clk);
        n_vec++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            n_err++; $display("FAIL x0_same got data %h busy %b want 0/0", rd_data, rd_busy);
        end
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if (busy_vec[0] !== 1'b0 || rd_data[0 +: DW] !== '0 || rd_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL x0_next got bv0 %b data %h busy %b want 0/0/0",
                              busy_vec[0], rd_data[0 +: DW], rd_busy[0]);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        bit want;
        idle();
        set_rd(0, 7);
        iss_en   = 1'b1;
        iss_addr = 5'd7;
        @(negedge clk);
        n_vec++;
        if (rd_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL sb_issue_cycle got %b want 0", rd_busy[0]);
        end
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if (busy_vec[7] !== 1'b1 || rd_busy[0] !== 1'b1) begin
            n_err++; $display("FAIL sb_set got bv %b rd_busy %b want 1/1", busy_vec[7], rd_busy[0]);
        end
        set_wr(0, 7, 64'h77);
`ifdef REGFILE_BYPASS_EN
        want = 1'b0;
`else
        want = 1'b1;
`endif
        #1;
        n_vec++;
        if (rd_busy[0] !== want) begin
            n_err++; $display("FAIL sb_wb_cycle got %b want %b", rd_busy[0], want);
        end
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if (busy_vec[7] !== 1'b0) begin
            n_err++; $display("FAIL sb_clear got %b want 0", busy_vec[7]);
        end
        set_wr(0, 7, 64'h78);
        iss_en   = 1'b1;
        iss_addr = 5'd7;
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if (busy_vec[7] !== 1'b1 || rd_data[0 +: DW] !== 64'h78) begin
            n_err++; $display("FAIL sb_set_wins got bv %b data %h want 1/78", busy_vec[7], rd_data[0 +: DW]);
        end
        set_wr(0, 7, 64'h79);
        tick();
        idle();
    endtask

    task automatic test_multi_read();
        logic [DW-1:0] a, b;
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        idle();
        set_wr(0, 1, a);
        set_wr(1, 2, b);
        tick();
        idle();
        iss_en   = 1'b1;
        iss_addr = 5'd2;
        tick();
        idle();
        set_rd(0, 1);
        set_rd(1, 2);
        set_rd(2, 1);
        @(negedge clk);
        n_vec++;
        if (rd_data !== {a, b, a}) begin
            n_err++; $display("FAIL mr_data got %h want %h", rd_data, {a, b, a});
        end
        n_vec++;
        if (rd_busy !== 3'b010) begin
            n_err++; $display("FAIL mr_busy got %b want 010", rd_busy);
        end
        set_wr(0, 2, b);
        tick();
        idle();
    endtask

    task automatic test_conflict();
        idle();
        @(negedge clk);
        n_vec++;
        if (wr_conflict !== 1'b0) begin
            n_err++; $display("FAIL cf_before got %b want 0", wr_conflict);
        end
        set_wr(0, 9, 64'hA);
        set_wr(1, 9, 64'hB);
        set_rd(0, 9);
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if (rd_data[0 +: DW] !== 64'hB || wr_conflict !== 1'b1) begin
            n_err++; $display("FAIL cf_result got data %h cf %b want B/1", rd_data[0 +: DW], wr_conflict);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            n_vec++;
            if (wr_conflict !== 1'b1) begin
                n_err++; $display("FAIL cf_sticky cycle %0d got %b want 1", c, wr_conflict);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        set_wr(0, 5, 64'hDEAD);
        iss_en   = 1'b1;
        iss_addr = 5'd5;
        set_rd(0, 5);
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if (rd_data[0 +: DW] !== 64'hDEAD || busy_vec[5] !== 1'b1) begin
            n_err++; $display("FAIL rm_pre got %h bv %b want DEAD/1", rd_data[0 +: DW], busy_vec[5]);
        end
        tick();
        set_wr(0, 5, 64'hBEEF);
        iss_en   = 1'b1;
        iss_addr = 5'd6;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (rd_data[0 +: DW] !== '0 || busy_vec !== '0 || wr_conflict !== 1'b0) begin
            n_err++; $display("FAIL rm_immediate got data %h bv %h cf %b want 0/0/0",
                              rd_data[0 +: DW], busy_vec, wr_conflict);
        end
        tick();
        idle();
        @(negedge clk);
        rst = 1'b0;
        tick();
        @(negedge clk);
        n_vec++;
        if (rd_data[0 +: DW] !== '0 || busy_vec !== '0 || rd_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL rm_after got data %h bv %h busy %b want 0/0/0",
                              rd_data[0 +: DW], busy_vec, rd_busy[0]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            int hi;
            hi = (it % 4 == 0) ? NREG - 1 : 7;
            for (int j = 0; j < NR; j++) set_rd(j, int'($urandom_range(0, hi)));
            for (int k = 0; k < NW; k++) begin
                wr_en[k]            = ($urandom_range(0, 2) != 0);
                wr_addr[k*AW +: AW] = AW'($urandom_range(0, hi));
                wr_data[k*DW +: DW] = {$urandom(), $urandom()};
            end
            iss_en   = ($urandom_range(0, 1) != 0);
            iss_addr = AW'($urandom_range(0, hi));
            @(negedge clk);
            for (int j = 0; j < NR; j++) begin
                int a;
                a = int'(rd_addr[j*AW +: AW]);
                n_vec++;
                if (rd_data[j*DW +: DW] !== exp_data(a)) begin
                    n_err++; $display("FAIL rnd_data it %0d port %0d x%0d got %h want %h",
                                      it, j, a, rd_data[j*DW +: DW], exp_data(a));
                end
                n_vec++;
                if (rd_busy[j] !== exp_busy(a)) begin
                    n_err++; $display("FAIL rnd_busy it %0d port %0d x%0d got %b want %b",
                                      it, j, a, rd_busy[j], exp_busy(a));
                end
            end
            n_vec++;
            if (busy_vec !== exp_bvec()) begin
                n_err++; $display("FAIL rnd_bvec it %0d got %h want %h", it, busy_vec, exp_bvec());
            end
            n_vec++;
            if (wr_conflict !== m_conf) begin
                n_err++; $display("FAIL rnd_conflict it %0d got %b want %b", it, wr_conflict, m_conf);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_scoreboard();
        test_multi_read();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
